// File: rtl/vend_pkg.sv
// Shared types and coin decoding for the vending session controller.
// Money is counted in coin units of 5.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Codes 00 and 11 are handshaked like real coins but carry no value.
    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  coin_value = 2'd1;
            COIN_2:  coin_value = 2'd2;
            default: coin_value = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Idle down-counter for COLLECT: reloads on clr, counts while en,
// and flags terminal count once TIMEOUT_CYC-1 idle cycles have elapsed.
module vend_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/vend_session_ctrl.sv
// Vending session sequencer: collect coins, vend once credit >= PRICE, pay change.
// Optional auto-refund of an idle COLLECT session with macro VEND_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no credit, ready for coins
// COLLECT | 0 < credit < PRICE, ready for coins or cancel
// VEND    | vend_req high until vend_ack
// CHANGE  | chg_req high, one unit paid per chg_ack until credit is 0
module vend_session_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE       = 3,
    parameter int CREDIT_W    = 3,
    parameter int SALES_W     = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    output logic                coin_ready,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [SALES_W-1:0]  sales_cnt,
    output logic                timeout_evt
);
    if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("vend_session_ctrl: illegal PRICE/CREDIT_W/TIMEOUT_CYC");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_t         state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] sum;
    logic                accept;
    logic                sale;
    logic                tmo_hit;

    assign accept = coin_valid && coin_ready;
    assign sum    = credit + CREDIT_W'(coin_value(coin));

`ifdef VEND_TIMEOUT_EN
    vend_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk (clk),
        .rst (rst),
        .clr (accept || (state != COLLECT)),
        .en  (state == COLLECT),
        .tc  (tmo_hit)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    // coin_ready is registered from the next state so it is low during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            credit     <= '0;
            sales_cnt  <= '0;
            coin_ready <= 1'b0;
        end else begin
            state      <= state_n;
            credit     <= credit_n;
            coin_ready <= (state_n == IDLE) || (state_n == COLLECT);
            if (sale) begin
                sales_cnt <= sales_cnt + SALES_W'(1);
            end
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        sale     = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    credit_n = sum;
                end
                // A coin arriving with cancel/timeout is added first, then refunded.
                if ((state == COLLECT) && (cancel || tmo_hit)) begin
                    state_n = CHANGE;
                end else if (credit_n >= PRICE_C) begin
                    state_n = VEND;
                end else if (credit_n != '0) begin
                    state_n = COLLECT;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    credit_n = credit - PRICE_C;
                    sale     = 1'b1;
                    state_n  = (credit_n != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_n = IDLE;
                end else if (chg_ack) begin
                    credit_n = credit - CREDIT_W'(1);
                    if (credit_n == '0) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        vend_req = (state == VEND);
        chg_req  = (state == CHANGE) && (credit != '0);
        busy     = (state == VEND) || (state == CHANGE);
    end

    assign timeout_evt = tmo_hit;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed bench for vend_session_ctrl with a behavioural money model checked every cycle.
// Timeout scenarios run only when VEND_TIMEOUT_EN is defined.
module tb_vend_session_ctrl;
    localparam int PRICE = 3;
    localparam int TMO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin = 2'b00;
    logic        cancel = 1'b0;
    logic        vend_ack = 1'b0;
    logic        chg_ack = 1'b0;
    logic        coin_ready, vend_req, chg_req, busy, timeout_evt;
    logic [2:0]  credit;
    logic [15:0] sales_cnt;

    int n_vec = 0;
    int n_err = 0;

    vend_session_ctrl #(
        .PRICE       (PRICE),
        .CREDIT_W    (3),
        .SALES_W     (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .coin_ready  (coin_ready),
        .cancel      (cancel),
        .vend_req    (vend_req),
        .vend_ack    (vend_ack),
        .chg_req     (chg_req),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .busy        (busy),
        .sales_cnt   (sales_cnt),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    // Behavioural model: money held, whether a vend or a payout is in progress.
    int m_credit = 0;
    int m_sales  = 0;
    int m_idle   = 0;
    bit m_vend   = 1'b0;
    bit m_chg    = 1'b0;
    bit m_ready  = 1'b0;

    function automatic int coin_units(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b10) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int c, s, idl;
        bit v, g, collecting, timed, acc;
        if (!rst) begin
            m_credit <= 0;
            m_sales  <= 0;
            m_idle   <= 0;
            m_vend   <= 1'b0;
            m_chg    <= 1'b0;
            m_ready  <= 1'b0;
        end else begin
            c = m_credit;
            s = m_sales;
            v = m_vend;
            g = m_chg;
            idl = 0;
            collecting = !v && !g && (c > 0);
            timed = 1'b0;
`ifdef VEND_TIMEOUT_EN
            timed = collecting && (m_idle == TMO - 1);
`endif
            acc = coin_valid && m_ready;
            if (!v && !g) begin
                if (acc) c = c + coin_units(coin);
                if (collecting && (cancel || timed)) g = 1'b1;
                else if (c >= PRICE) v = 1'b1;
                if (!v && !g && collecting && !acc) idl = m_idle + 1;
            end else if (v) begin
                if (vend_ack) begin
                    c = c - PRICE;
                    s = (s + 1) % 65536;
                    v = 1'b0;
                    g = (c > 0);
                end
            end else begin
                if (chg_ack && (c > 0)) c = c - 1;
                if (c == 0) g = 1'b0;
            end
            m_credit <= c;
            m_sales  <= s;
            m_vend   <= v;
            m_chg    <= g;
            m_ready  <= !v && !g;
            m_idle   <= idl;
        end
    end

    int n_hs = 0;
    int n_vend_cyc = 0;
    int n_chg_cyc = 0;
    always @(posedge clk) if (rst && chg_req && chg_ack) n_hs <= n_hs + 1;
    always @(negedge clk) if (vend_req) n_vend_cyc <= n_vend_cyc + 1;
    always @(negedge clk) if (chg_req) n_chg_cyc <= n_chg_cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("model.coin_ready", int'(coin_ready), int'(m_ready));
            chk("model.vend_req", int'(vend_req), int'(m_vend));
            chk("model.chg_req", int'(chg_req), int'(m_chg && (m_credit > 0)));
            chk("model.busy", int'(busy), int'(m_vend || m_chg));
            chk("model.credit", int'(credit), m_credit);
            chk("model.sales_cnt", int'(sales_cnt), m_sales);
`ifdef VEND_TIMEOUT_EN
            chk("model.timeout_evt", int'(timeout_evt),
                int'(!m_vend && !m_chg && (m_credit > 0) && (m_idle == TMO - 1)));
`else
            chk("model.timeout_evt", int'(timeout_evt), 0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code, input bit with_cancel = 1'b0);
        coin_valid = 1'b1;
        coin       = code;
        cancel     = with_cancel;
        step();
        coin_valid = 1'b0;
        coin       = 2'b00;
        cancel     = 1'b0;
    endtask

    task automatic pay_change();
        for (int i = 0; i < 20; i++) begin
            if (!chg_req) break;
            chg_ack = 1'b1;
            step();
            chg_ack = 1'b0;
        end
        chk("pay_change.done", int'(chg_req), 0);
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic run_timeout(input int insert_at, input int exp_idx, input int exp_credit);
        int first;
        first = 0;
        for (int idx = 1; idx <= 50; idx++) begin
            if (timeout_evt) begin
                first = idx;
                chk("tmo.credit", int'(credit), exp_credit);
                break;
            end
            if (idx == insert_at) put_coin(2'b01);
            else step();
        end
        chk("tmo.cycle", first, exp_idx);
        step();
        chk("tmo.pulse_len", int'(timeout_evt), 0);
        chk("tmo.chg_req", int'(chg_req), 1);
    endtask
`endif

    initial begin
        int hs0, vc0, cc0;
        fork
            compare_loop();
        join_none

        // Reset held with input activity
        #2 rst = 1'b0;
        coin_valid = 1'b1; vend_ack = 1'b1; chg_ack = 1'b1; coin = 2'b10;
        step(); step(); step();
        chk("rst.coin_ready", int'(coin_ready), 0);
        chk("rst.vend_req", int'(vend_req), 0);
        chk("rst.chg_req", int'(chg_req), 0);
        chk("rst.credit", int'(credit), 0);
        chk("rst.sales_cnt", int'(sales_cnt), 0);
        rst = 1'b1; coin_valid = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0; coin = 2'b00;
        step();
        chk("release.coin_ready", int'(coin_ready), 1);
        chk("release.credit", int'(credit), 0);

        // Exact payment
        cc0 = n_chg_cyc;
        put_coin(2'b10);
        chk("exact.credit1", int'(credit), 2);
        chk("exact.ready1", int'(coin_ready), 1);
        put_coin(2'b01);
        chk("exact.credit2", int'(credit), 3);
        chk("exact.vend_req", int'(vend_req), 1);
        chk("exact.coin_ready", int'(coin_ready), 0);
        step(); step(); step();
        chk("exact.vend_hold", int'(vend_req), 1);
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("exact.credit_after", int'(credit), 0);
        chk("exact.vend_drop", int'(vend_req), 0);
        chk("exact.sales", int'(sales_cnt), 1);
        chk("exact.idle_ready", int'(coin_ready), 1);
        step();
        chk("exact.no_chg", n_chg_cyc - cc0, 0);

        // Overpay with one unit of change
        hs0 = n_hs;
        put_coin(2'b10);
        put_coin(2'b10);
        chk("over.credit", int'(credit), 4);
        chk("over.vend_req", int'(vend_req), 1);
        step();
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("over.credit_rem", int'(credit), 1);
        chk("over.chg_req", int'(chg_req), 1);
        chk("over.sales", int'(sales_cnt), 2);
        repeat (5) step();
        chk("over.chg_wait", int'(chg_req), 1);
        chg_ack = 1'b1; step(); chg_ack = 1'b0;
        chk("over.credit_done", int'(credit), 0);
        chk("over.chg_drop", int'(chg_req), 0);
        chk("over.ready", int'(coin_ready), 1);
        chk("over.hs", n_hs - hs0, 1);

        // Cancel refunds the full credit
        hs0 = n_hs;
        put_coin(2'b10);
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("cancel.chg_req", int'(chg_req), 1);
        chk("cancel.credit", int'(credit), 2);
        pay_change();
        chk("cancel.hs", n_hs - hs0, 2);
        chk("cancel.sales", int'(sales_cnt), 2);

        // Coin and cancel together: sum reaches PRICE but is refunded
        hs0 = n_hs; vc0 = n_vend_cyc;
        put_coin(2'b10);
        put_coin(2'b01, 1'b1);
        chk("cc.credit", int'(credit), 3);
        chk("cc.vend_req", int'(vend_req), 0);
        chk("cc.chg_req", int'(chg_req), 1);
        pay_change();
        step();
        chk("cc.hs", n_hs - hs0, 3);
        chk("cc.no_vend", n_vend_cyc - vc0, 0);
        chk("cc.sales", int'(sales_cnt), 2);

        // Robustness: invalid coin, stray acks, cancel in IDLE
        put_coin(2'b11);
        chk("bad.credit", int'(credit), 0);
        chk("bad.ready", int'(coin_ready), 1);
        chg_ack = 1'b1; vend_ack = 1'b1; cancel = 1'b1;
        step();
        chg_ack = 1'b0; vend_ack = 1'b0; cancel = 1'b0;
        chk("stray.credit", int'(credit), 0);
        chk("stray.chg_req", int'(chg_req), 0);
        chk("stray.sales", int'(sales_cnt), 2);
        put_coin(2'b01);
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("stray.collect_credit", int'(credit), 1);
        put_coin(2'b11);
        chk("bad.collect_credit", int'(credit), 1);
        hs0 = n_hs;
        cancel = 1'b1; step(); cancel = 1'b0;
        pay_change();
        chk("stray.hs", n_hs - hs0, 1);

        // Asynchronous reset in the middle of CHANGE
        put_coin(2'b10);
        put_coin(2'b10);
        vend_ack = 1'b1; step(); vend_ack = 1'b0;
        chk("midrst.pre_chg", int'(chg_req), 1);
        chk("midrst.pre_credit", int'(credit), 1);
        rst = 1'b0;
        #1;
        chk("midrst.credit", int'(credit), 0);
        chk("midrst.chg_req", int'(chg_req), 0);
        chk("midrst.sales", int'(sales_cnt), 0);
        step();
        rst = 1'b1;
        step();
        chk("midrst.ready", int'(coin_ready), 1);

`ifdef VEND_TIMEOUT_EN
        hs0 = n_hs;
        put_coin(2'b01);
        run_timeout(0, 20, 1);
        pay_change();
        chk("tmo1.hs", n_hs - hs0, 1);
        chk("tmo1.ready", int'(coin_ready), 1);
        put_coin(2'b01);
        run_timeout(15, 35, 2);
        pay_change();
        chk("tmo2.ready", int'(coin_ready), 1);
`else
        put_coin(2'b01);
        repeat (2 * TMO) step();
        chk("notmo.credit", int'(credit), 1);
        chk("notmo.ready", int'(coin_ready), 1);
        chk("notmo.chg_req", int'(chg_req), 0);
        cancel = 1'b1; step(); cancel = 1'b0;
        pay_change();
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
